// File: rtl/pwm_brightness_gen.sv
// Brightness PWM generator: maps a 3-bit selection code to a duty target and
// drives a fixed-frequency PWM, updating (optionally fading) duty at period boundaries.
module pwm_brightness_gen #(
  parameter int PRESCALE  = 200,
  parameter int PERIOD    = 250,
  parameter int RAMP_STEP = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] sel,
  input  logic       en,
  output logic       pwm_out,
  output logic       period_start,
  output logic       busy,
  output logic [7:0] duty_cur
);

  localparam int              PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [7:0]      PER_LAST = 8'(PERIOD - 1);
  localparam logic [7:0]      T_Q1     = 8'(PERIOD / 4);
  localparam logic [7:0]      T_Q2     = 8'(PERIOD / 2);
  localparam logic [7:0]      T_Q3     = 8'((3 * PERIOD) / 4);
  localparam logic [7:0]      T_FULL   = 8'(PERIOD);
  localparam logic [8:0]      STEP9    = 9'(RAMP_STEP);
  localparam logic [7:0]      STEP8    = 8'(RAMP_STEP);

  logic [PW-1:0] pre_cnt;
  logic [7:0]    per_cnt;
  logic [7:0]    target;
  logic          tick;
  logic          period_end;

  // Next duty value: move one step toward target, landing exactly on it when close.
  function automatic logic [7:0] ramp_next(input logic [7:0] cur, input logic [7:0] tgt);
    logic [8:0] diff;
    logic [7:0] res;
    if (tgt >= cur) begin
      diff = {1'b0, tgt} - {1'b0, cur};
    end else begin
      diff = {1'b0, cur} - {1'b0, tgt};
    end
    if ((RAMP_STEP == 0) || (diff <= STEP9)) begin
      res = tgt;
    end else if (tgt > cur) begin
      res = cur + STEP8;
    end else begin
      res = cur - STEP8;
    end
    return res;
  endfunction

  // Selection code to duty target; illegal codes turn the LED off.
  always_comb begin
    target = 8'd0;
    case (sel)
      3'd0:    target = 8'd0;
      3'd1:    target = T_Q1;
      3'd2:    target = T_Q2;
      3'd3:    target = T_Q3;
      3'd4:    target = T_FULL;
      default: target = 8'd0;
    endcase
  end

  assign tick       = en && (pre_cnt == PRE_LAST);
  assign period_end = tick && (per_cnt == PER_LAST);

  // Prescaler and period counters; both parked at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      per_cnt <= 8'd0;
    end else if (!en) begin
      pre_cnt <= '0;
      per_cnt <= 8'd0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (tick) begin
        per_cnt <= (per_cnt == PER_LAST) ? 8'd0 : per_cnt + 8'd1;
      end else begin
        per_cnt <= per_cnt;
      end
    end
  end

  // Duty only changes at a period boundary, so no runt pulses appear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_cur <= 8'd0;
    end else if (period_end) begin
      duty_cur <= ramp_next(duty_cur, target);
    end else begin
      duty_cur <= duty_cur;
    end
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_out      <= 1'b0;
      period_start <= 1'b0;
      busy         <= 1'b0;
    end else begin
      pwm_out      <= en && (per_cnt < duty_cur);
      period_start <= period_end;
      busy         <= (duty_cur != target);
    end
  end

endmodule

// File: tb/tb_pwm_brightness_gen.sv
// Randomized self-checking bench for pwm_brightness_gen: two instances with
// different parameter sets, each compared every clock against a time-based model.
module tb_pwm_brightness_gen;

  logic       clk;
  logic       rst_n;
  logic [2:0] sel_a, sel_b;
  logic       en_a, en_b;
  logic       pwm_a, ps_a, busy_a;
  logic       pwm_b, ps_b, busy_b;
  logic [7:0] duty_a, duty_b;

  int total = 0;
  int bad   = 0;

  int pre_p[2]  = '{2, 1};
  int per_p[2]  = '{8, 100};
  int step_p[2] = '{0, 10};

  // model state: k = clocks counted since counting (re)started
  int k[2];
  int m_duty[2];
  bit m_pwm[2];
  bit m_ps[2];
  bit m_busy[2];

  pwm_brightness_gen #(.PRESCALE(2), .PERIOD(8), .RAMP_STEP(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .sel(sel_a), .en(en_a),
    .pwm_out(pwm_a), .period_start(ps_a), .busy(busy_a), .duty_cur(duty_a)
  );

  pwm_brightness_gen #(.PRESCALE(1), .PERIOD(100), .RAMP_STEP(10)) dut_b (
    .clk(clk), .rst_n(rst_n), .sel(sel_b), .en(en_b),
    .pwm_out(pwm_b), .period_start(ps_b), .busy(busy_b), .duty_cur(duty_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int tgt_of(input int i, input logic [2:0] s);
    case (s)
      3'd0:    return 0;
      3'd1:    return per_p[i] / 4;
      3'd2:    return per_p[i] / 2;
      3'd3:    return (3 * per_p[i]) / 4;
      3'd4:    return per_p[i];
      default: return 0;
    endcase
  endfunction

  function automatic int ramp(input int d, input int t, input int st);
    int diff;
    diff = (t > d) ? t - d : d - t;
    if (st == 0 || diff <= st) return t;
    return (t > d) ? d + st : d - st;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      k[i] = 0; m_duty[i] = 0; m_pwm[i] = 0; m_ps[i] = 0; m_busy[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [2:0] s, input logic e);
    int len, tgt, pos;
    tgt = tgt_of(i, s);
    len = pre_p[i] * per_p[i];
    pos = (k[i] / pre_p[i]) % per_p[i];
    m_pwm[i]  = e && (pos < m_duty[i]);
    m_busy[i] = (m_duty[i] != tgt);
    m_ps[i]   = e && ((k[i] % len) == len - 1);
    if (m_ps[i]) m_duty[i] = ramp(m_duty[i], tgt, step_p[i]);
    k[i] = e ? k[i] + 1 : 0;
  endtask

  task automatic cyc(input int n);
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      model_step(0, sel_a, en_a);
      model_step(1, sel_b, en_b);
      #1;
      chk("a_pwm", pwm_a, m_pwm[0]);
      chk("a_pstart", ps_a, m_ps[0]);
      chk("a_busy", busy_a, m_busy[0]);
      chk("a_duty", duty_a, m_duty[0]);
      chk("b_pwm", pwm_b, m_pwm[1]);
      chk("b_pstart", ps_b, m_ps[1]);
      chk("b_busy", busy_b, m_busy[1]);
      chk("b_duty", duty_b, m_duty[1]);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_a_pwm"}, pwm_a, 0);
    chk({tag, "_a_ps"}, ps_a, 0);
    chk({tag, "_a_busy"}, busy_a, 0);
    chk({tag, "_a_duty"}, duty_a, 0);
    chk({tag, "_b_pwm"}, pwm_b, 0);
    chk({tag, "_b_ps"}, ps_b, 0);
    chk({tag, "_b_busy"}, busy_b, 0);
    chk({tag, "_b_duty"}, duty_b, 0);
  endtask

  initial begin
    bit found;
    int ps_count;
    rst_n = 1'b0; sel_a = 3'd0; sel_b = 3'd0; en_a = 1'b1; en_b = 1'b1;
    #2;
    chk_zero("rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // default: LED off, period_start every 16 clocks on instance A
    ps_count = 0;
    for (int j = 0; j < 64; j++) begin
      cyc(1);
      if (ps_a) ps_count++;
    end
    chk("a_ps_count64", ps_count, 4);

    // step response with a mid-period sel change
    cyc(5);
    sel_a = 3'd2;
    cyc(60);
    chk("a_duty_half", duty_a, 4);

    // extremes and illegal code
    sel_a = 3'd4;
    cyc(48);
    chk("a_duty_full", duty_a, 8);
    sel_a = 3'd6;
    cyc(48);
    chk("a_duty_illegal", duty_a, 0);

    // fade on instance B
    sel_b = 3'd4;
    cyc(1100);
    chk("b_fade_up_duty", duty_b, 100);
    chk("b_fade_up_busy", busy_b, 0);
    sel_b = 3'd1;
    cyc(1000);
    chk("b_fade_down_duty", duty_b, 25);
    chk("b_fade_down_busy", busy_b, 0);

    // enable gating during the high phase
    sel_a = 3'd2;
    cyc(32);
    found = 1'b0;
    for (int t = 0; t < 64 && !found; t++) begin
      cyc(1);
      if (pwm_a) found = 1'b1;
    end
    chk("a_pwm_high_seen", found, 1);
    en_a = 1'b0;
    cyc(1);
    chk("a_pwm_gated", pwm_a, 0);
    cyc(6);
    chk("a_duty_frozen", duty_a, 4);
    en_a = 1'b1;
    cyc(1);
    chk("a_pwm_restart", pwm_a, 1);
    cyc(20);

    // randomized operation
    for (int j = 0; j < 3000; j++) begin
      if ($urandom_range(0, 49) == 0) sel_a = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) sel_b = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) en_a = ~en_a;
      if ($urandom_range(0, 299) == 0) en_b = ~en_b;
      cyc(1);
    end

    // asynchronous reset in the middle of a fade
    en_a = 1'b1; en_b = 1'b1;
    sel_b = (m_duty[1] < 50) ? 3'd4 : 3'd0;
    cyc(250);
    chk("b_busy_midramp", busy_b, 1);
    @(posedge clk);
    model_step(0, sel_a, en_a);
    model_step(1, sel_b, en_b);
    #3;
    rst_n = 1'b0;
    #1;
    chk_zero("arst");
    model_reset();
    sel_a = 3'd2;
    @(negedge clk);
    rst_n = 1'b1;
    cyc(20);
    chk("a_duty_after_rst", duty_a, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
